imm_extend_pipe: RTL and testbench
==================================

Name: imm_extend_pipe

Overview:
Registered, parametrised successor to the combinational sign extender. It sits between decode and the execute operand mux. Each operand is extended by a per-transaction mode: byte, half, word or full width, signed or unsigned, with an optional left-shift-by-16 for LUI-class immediates. Transfers use valid/ready handshakes with a 2-entry skid buffer, so the input side never sees a combinational path from out_ready.

Parameters:
SIZE_IN, 32, width of input operand bus a; must be >= 32.
SIZE_OUT, 64, width of out_data; must be >= SIZE_IN + 16.
TAG_W, 5, width of sideband tag (destination register id) carried alongside the data.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous reset, active-high.
in_valid  input  1  input transaction present.
in_ready  output  1  block can accept an input this cycle.
a  input  SIZE_IN  operand to extend.
size_sel  input  2  source width: 00 byte [7:0], 01 half [15:0], 10 word [31:0], 11 full [SIZE_IN-1:0].
sgn  input  1  1 = sign-extend from the MSB of the selected field; 0 = zero-extend.
shl16  input  1  1 = shift the extended result left 16, zero-fill, truncate to SIZE_OUT.
in_tag  input  TAG_W  sideband, passed through unchanged.
out_valid  output  1  output transaction present.
out_ready  input  1  consumer accepts this cycle.
out_data  output  SIZE_OUT  extended result.
out_tag  output  TAG_W  tag matching out_data.

Behaviour:
- Reset is asynchronous and active-high.
- While rst is high, all registers clear: out_valid=0, out_data=0, out_tag=0, skid_valid=0, skid data/tag=0.
- in_ready = !skid_valid, driven directly from a register, so it reads 1 during and after reset. Inputs are ignored while rst is high.
- Input accept: in_valid && in_ready at a rising edge. Output transfer: out_valid && out_ready at a rising edge.
- Extension is combinational on the input side:
  - Select field f per size_sel.
  - Fill upper bits with f's MSB if sgn=1, else 0, out to SIZE_OUT.
  - If shl16=1, result = {ext[SIZE_OUT-17:0], 16'b0}.
  - The computed result is registered into the output stage or the skid stage.
- Latency: an accepted input appears on out_data/out_valid the cycle after acceptance when the output stage is empty or transferring. Throughput is 1 per cycle with out_ready held high.
- Stage update per edge, with out_busy = out_valid && !out_ready:
  - Output empty or transferring, skid empty: accepted input -> output stage. No input -> out_valid=0.
  - Output empty or transferring, skid full: skid -> output stage, skid_valid=0. No input is accepted, since in_ready=0.
  - out_busy, input accepted (skid necessarily empty): input -> skid, skid_valid=1. Output stage holds.
  - out_busy, no input: everything holds.
- Ordering is strictly FIFO. At most 2 transactions are in flight.
- out_data and out_tag are stable while out_valid && !out_ready.
- When out_valid=0, out_data and out_tag hold their last value and must not be relied on.
- Reset mid-operation drops both entries immediately. No transaction is emitted after rst deasserts until a new input is accepted.
- size_sel=11 with sgn=1 reproduces the legacy sign extender exactly (shl16=0).

Test Plan:
1. Reset then idle: rst high with in_valid=1 -> out_valid=0, out_data=0, in_ready=1. After release with in_valid=0 -> out_valid stays 0.
2. Mode sweep, out_ready=1, a=32'h0000_8080:
   - size_sel=00, sgn=1 -> 64'hFFFF_FFFF_FFFF_FF80
   - size_sel=00, sgn=0 -> 64'h80
   - size_sel=01, sgn=1 -> 64'hFFFF_FFFF_FFFF_8080
   - size_sel=10, sgn=1 -> 64'h8080
   Each result appears 1 cycle after acceptance.
3. LUI: a=32'h0000_8001, size_sel=01, sgn=1, shl16=1 -> out_data=64'hFFFF_FFFF_8001_0000. Legacy check: a=32'hFFFF_FFFE, size_sel=11, sgn=1 -> 64'hFFFF_FFFF_FFFF_FFFE.
4. Backpressure: stream tags 1,2,3,4 back-to-back with out_ready=0 for 3 cycles.
   - Tag 1 is held in the output stage, tag 2 in the skid.
   - in_ready drops to 0 the cycle after tag 2 is accepted.
   - After out_ready=1, tags emerge 1,2,3,4 in order with no loss or duplication.
5. Full throughput: 20 transactions with in_valid and out_ready both high -> 20 outputs on consecutive cycles, in_ready constantly 1.
6. Reset mid-flight: with 2 entries buffered and out_ready=0, pulse rst asynchronously between clock edges -> out_valid and in_ready respond before the next edge (0 and 1). No stale tag appears afterwards.

Source files
------------

// File: rtl/imm_extend_pipe.sv
// ----------------------------------------------------------------------------
// imm_extend_pipe
//
// Registered immediate/operand extender placed between decode and the
// execute operand mux. Each transaction selects a source field width
// (byte/half/word/full), signed or unsigned fill, and an optional
// left-shift-by-16 for LUI-class immediates. The result and its tag are
// carried through a valid/ready pipeline stage with a one-entry skid buffer.
// in_ready comes straight from the skid-valid flop, so it has no
// combinational path from out_ready.
//
// Parameters:
//   SIZE_IN   width of operand a (>= 32)
//   SIZE_OUT  width of out_data (>= SIZE_IN + 16)
//   TAG_W     width of the sideband tag (destination register id)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   in_valid   input transaction present
//   in_ready   block can accept an input this cycle
//   a          operand to extend
//   size_sel   00 byte, 01 half, 10 word, 11 full SIZE_IN
//   sgn        1 = sign-extend from field MSB, 0 = zero-extend
//   shl16      1 = shift extended result left 16, zero-fill
//   in_tag     sideband tag, passed through unchanged
//   out_valid  output transaction present
//   out_ready  consumer accepts this cycle
//   out_data   extended result
//   out_tag    tag matching out_data
// ----------------------------------------------------------------------------
module imm_extend_pipe #(
    parameter int SIZE_IN  = 32,
    parameter int SIZE_OUT = 64,
    parameter int TAG_W    = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SIZE_IN-1:0]  a,
    input  logic [1:0]          size_sel,
    input  logic                sgn,
    input  logic                shl16,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SIZE_OUT-1:0] out_data,
    output logic [TAG_W-1:0]    out_tag
);

    // One pipeline entry: extended result plus its tag.
    typedef struct packed {
        logic [SIZE_OUT-1:0] data;
        logic [TAG_W-1:0]    tag;
    } entry_t;

    localparam logic [1:0] SEL_BYTE = 2'b00;
    localparam logic [1:0] SEL_HALF = 2'b01;
    localparam logic [1:0] SEL_WORD = 2'b10;
    localparam logic [1:0] SEL_FULL = 2'b11;

    // ------------------------------------------------------------------
    // Extension datapath (input side, combinational)
    // ------------------------------------------------------------------
    logic                w_msb;
    logic [SIZE_OUT-1:0] w_ext;
    logic [SIZE_OUT-1:0] w_result;
    entry_t              w_in_entry;

    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves it
        // unassigned and no latch is inferred.
        w_msb = 1'b0;
        w_ext = '0;
        case (size_sel)
            SEL_BYTE: begin
                w_msb = sgn & a[7];
                w_ext = {{(SIZE_OUT-8){w_msb}}, a[7:0]};
            end
            SEL_HALF: begin
                w_msb = sgn & a[15];
                w_ext = {{(SIZE_OUT-16){w_msb}}, a[15:0]};
            end
            SEL_WORD: begin
                w_msb = sgn & a[31];
                w_ext = {{(SIZE_OUT-32){w_msb}}, a[31:0]};
            end
            SEL_FULL: begin
                w_msb = sgn & a[SIZE_IN-1];
                w_ext = {{(SIZE_OUT-SIZE_IN){w_msb}}, a};
            end
            default: begin
                w_msb = 1'b0;
                w_ext = '0;
            end
        endcase
        // LUI-class: shift left 16 with zero fill; the top 16 bits drop off.
        w_result = shl16 ? {w_ext[SIZE_OUT-17:0], 16'b0} : w_ext;
    end

    assign w_in_entry = '{data: w_result, tag: in_tag};

    // ------------------------------------------------------------------
    // Output stage + skid buffer
    // ------------------------------------------------------------------
    entry_t r_out;
    logic   r_out_valid;
    entry_t r_skid;
    logic   r_skid_valid;

    logic w_accept;    // input handshake completes at this edge
    logic w_out_free;  // output stage is empty or is transferring

    // in_ready depends only on the skid flop, never on out_ready.
    assign in_ready   = ~r_skid_valid;
    assign w_accept   = in_valid & ~r_skid_valid;
    assign w_out_free = ~r_out_valid | out_ready;

    // NOTE: every flop here, data included, is cleared by reset so nothing
    // stale can surface on out_data/out_tag after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out        <= '0;
            r_out_valid  <= 1'b0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge state regardless of statement order.
            if (r_skid_valid) begin
                // Older entry in the skid goes first; in_ready was 0, so
                // no input can be accepted on this edge.
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_out       <= w_in_entry;
                r_out_valid <= 1'b1;
            end else begin
                // Data/tag hold their last value; only valid drops.
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            // Output stalled: park the new entry in the skid buffer.
            r_skid       <= w_in_entry;
            r_skid_valid <= 1'b1;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out.data;
    assign out_tag   = r_out.tag;

endmodule

// File: tb/tb_imm_extend_pipe.sv
module tb_imm_extend_pipe;

    localparam int SIZE_IN  = 32;
    localparam int SIZE_OUT = 64;
    localparam int TAG_W    = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [SIZE_IN-1:0]  a;
    logic [1:0]          size_sel;
    logic                sgn;
    logic                shl16;
    logic [TAG_W-1:0]    in_tag;
    logic                out_valid;
    logic                out_ready;
    logic [SIZE_OUT-1:0] out_data;
    logic [TAG_W-1:0]    out_tag;

    imm_extend_pipe #(
        .SIZE_IN (SIZE_IN),
        .SIZE_OUT(SIZE_OUT),
        .TAG_W   (TAG_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .size_sel (size_sel),
        .sgn      (sgn),
        .shl16    (shl16),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_tag  (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [1:0]  sel;
        logic        sgn;
        logic        shl;
        logic [63:0] exp;
    } vec_t;

    typedef struct {
        logic [63:0]      data;
        logic [TAG_W-1:0] tag;
    } sb_t;

    sb_t         sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_out   = 0;
    logic [63:0] cur_exp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge with inputs already driven. Records handshakes that
    // will complete on the coming posedge, then advances to the next negedge.
    task automatic cycle();
        sb_t e;
        if (in_valid && in_ready) begin
            e.data = cur_exp;
            e.tag  = in_tag;
            sb.push_back(e);
        end
        if (out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got tag %0d data %h, expected no output", out_tag, out_data);
            end else begin
                e = sb.pop_front();
                check("out_data", out_data, e.data);
                check("out_tag", {59'b0, out_tag}, {59'b0, e.tag});
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Full-width zero-extended transaction used for ordering tests.
    task automatic drive_plain(input logic [TAG_W-1:0] tag);
        in_valid = 1'b1;
        a        = $urandom;
        size_sel = 2'b11;
        sgn      = 1'b0;
        shl16    = 1'b0;
        in_tag   = tag;
        cur_exp  = {32'b0, a};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    vec_t vecs[8];

    initial begin
        int out_base;
        int next;
        int stalls;
        int gaps;
        logic acc;

        vecs[0] = '{32'h0000_8080, 2'b00, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FF80};
        vecs[1] = '{32'h0000_8080, 2'b00, 1'b0, 1'b0, 64'h0000_0000_0000_0080};
        vecs[2] = '{32'h0000_8080, 2'b01, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_8080};
        vecs[3] = '{32'h0000_8080, 2'b10, 1'b1, 1'b0, 64'h0000_0000_0000_8080};
        vecs[4] = '{32'h0000_8001, 2'b01, 1'b1, 1'b1, 64'hFFFF_FFFF_8001_0000};
        vecs[5] = '{32'hFFFF_FFFE, 2'b11, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[6] = '{32'hFFFF_FFFE, 2'b11, 1'b0, 1'b1, 64'h0000_FFFF_FFFE_0000};
        vecs[7] = '{32'h8000_0000, 2'b11, 1'b1, 1'b1, 64'hFFFF_8000_0000_0000};

        // ---- 1. reset then idle ------------------------------------------
        rst       = 1'b1;
        in_valid  = 1'b1;
        a         = 32'hDEAD_BEEF;
        size_sel  = 2'b11;
        sgn       = 1'b1;
        shl16     = 1'b0;
        in_tag    = 5'd7;
        out_ready = 1'b0;
        cur_exp   = '0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_tag", {59'b0, out_tag}, 64'd0);
        check("rst_in_ready", {63'b0, in_ready}, 64'd1);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) cycle();
        check("idle_out_valid", {63'b0, out_valid}, 64'd0);

        // ---- 2/3. mode sweep, LUI, legacy --------------------------------
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            a        = vecs[i].a;
            size_sel = vecs[i].sel;
            sgn      = vecs[i].sgn;
            shl16    = vecs[i].shl;
            in_tag   = TAG_W'(i + 8);
            cur_exp  = vecs[i].exp;
            cycle();
            in_valid = 1'b0;
            check("latency_out_valid", {63'b0, out_valid}, 64'd1);
            cycle();
        end

        // ---- 4. backpressure ----------------------------------------------
        out_ready = 1'b0;
        out_base  = n_out;
        drive_plain(5'd1);
        check("bp_in_ready_t1", {63'b0, in_ready}, 64'd1);
        cycle();
        drive_plain(5'd2);
        check("bp_out_valid_t1", {63'b0, out_valid}, 64'd1);
        check("bp_out_tag_t1", {59'b0, out_tag}, 64'd1);
        check("bp_in_ready_t2", {63'b0, in_ready}, 64'd1);
        cycle();
        drive_plain(5'd3);
        check("bp_in_ready_after_t2", {63'b0, in_ready}, 64'd0);
        check("bp_out_tag_hold", {59'b0, out_tag}, 64'd1);
        cycle();
        check("bp_out_tag_stable", {59'b0, out_tag}, 64'd1);
        check("bp_in_ready_still_low", {63'b0, in_ready}, 64'd0);
        out_ready = 1'b1;
        next      = 3;
        for (int c = 0; c < 20 && (next <= 4 || sb.size() > 0 || out_valid); c++) begin
            if (next <= 4) begin
                if (in_tag != TAG_W'(next)) drive_plain(TAG_W'(next));
            end else begin
                in_valid = 1'b0;
            end
            acc = in_valid && in_ready;
            cycle();
            if (acc) next++;
        end
        in_valid = 1'b0;
        check("bp_output_count", 64'(n_out - out_base), 64'd4);
        check("bp_sb_empty", 64'(sb.size()), 64'd0);

        // ---- 5. full throughput -------------------------------------------
        out_ready = 1'b1;
        out_base  = n_out;
        stalls    = 0;
        gaps      = 0;
        for (int c = 0; c <= 20; c++) begin
            if (c < 20) begin
                in_valid = 1'b1;
                a        = $urandom;
                size_sel = 2'b10;
                sgn      = 1'b1;
                shl16    = 1'b0;
                in_tag   = TAG_W'(c);
                cur_exp  = {{32{a[31]}}, a};
                if (!in_ready) stalls++;
            end else begin
                in_valid = 1'b0;
            end
            if (c >= 1 && !out_valid) gaps++;
            cycle();
        end
        check("tp_in_ready_stalls", 64'(stalls), 64'd0);
        check("tp_output_gaps", 64'(gaps), 64'd0);
        check("tp_output_count", 64'(n_out - out_base), 64'd20);

        // ---- 6. asynchronous reset mid-flight -----------------------------
        out_ready = 1'b0;
        drive_plain(5'd21);
        cycle();
        drive_plain(5'd22);
        cycle();
        in_valid = 1'b0;
        check("mf_in_ready_full", {63'b0, in_ready}, 64'd0);
        check("mf_out_valid_full", {63'b0, out_valid}, 64'd1);
        #2 rst = 1'b1;
        #1;
        check("mf_async_out_valid", {63'b0, out_valid}, 64'd0);
        check("mf_async_in_ready", {63'b0, in_ready}, 64'd1);
        #1 rst = 1'b0;
        sb.delete();
        out_ready = 1'b1;
        @(negedge clk);
        check("mf_post_rst_out_valid", {63'b0, out_valid}, 64'd0);
        out_base = n_out;
        repeat (4) cycle();
        check("mf_no_stale_output", 64'(n_out - out_base), 64'd0);
        drive_plain(5'd30);
        cycle();
        in_valid = 1'b0;
        check("mf_fresh_valid", {63'b0, out_valid}, 64'd1);
        cycle();
        check("mf_fresh_count", 64'(n_out - out_base), 64'd1);

        check("final_sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
